fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage sitting directly upstream of the byte-addressed instruction ROM and downstream-feeding the decoder. It owns the program counter, drives the ROM address, selects the next PC (sequential, branch, jump, register jump), and latches the returned instruction into the IF/ID pipeline register with stall, flush and valid control. A small state machine handles halt detection so the pipeline drains cleanly at program end.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_OPCODE, 6'b111111: instruction[31:26] value treated as halt.

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- stall  input  1  hold PC and IF/ID contents.
- pc_src  input  2  next-PC select: 0 sequential, 1 branch, 2 jump, 3 register jump.
- branch_imm  input  16  branch offset in words, signed.
- jump_index  input  26  J-type target index.
- jr_target  input  32  register-jump target.
- instruction  input  32  ROM data for current PC (combinational ROM).
- PC  output  32  current fetch address to ROM.
- if_instr  output  32  IF/ID instruction.
- if_pc4  output  32  IF/ID PC+4.
- if_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch has stopped on a halt instruction.

## Operation
- States: RUN, HALT. Reset enters RUN.
- Reset values: PC=RESET_PC, if_instr=0, if_pc4=0, if_valid=0, halted=0.
- pc4 = PC + 4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
- Targets: branch = pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00}; jump = {pc4[31:28], jump_index, 2'b00}; register = {jr_target[31:2], 2'b00} (low bits forced to 0).
- Redirect = pc_src != 0. Redirect is issued by a later stage and implies the instruction currently in IF/ID and in fetch is wrong-path.
- Priority each edge: Reset > redirect > stall > normal.
  - Redirect: PC <= selected target; IF/ID cleared (if_valid=0, if_instr=0); stall ignored; state -> RUN.
  - Stall (no redirect): PC and IF/ID unchanged.
  - Normal in RUN: PC <= pc4; if_instr <= instruction; if_pc4 <= pc4; if_valid <= 1.
  - Normal in HALT: PC unchanged; if_valid <= 0; if_instr <= 0.
- Halt detect (RUN, normal advance, instruction[31:26]==HALT_OPCODE): halt instruction is latched into IF/ID with if_valid=1 exactly once; PC does not advance (stays at halt address); state -> HALT; halted=1.
- halted = 1 iff state is HALT.

## Timing
- PC is a registered output; ROM is combinational, so instruction is sampled at the same edge that advances PC: one-cycle fetch latency from PC change to if_instr update.
- Redirect target appears on PC the cycle after pc_src is asserted; first correct-path instruction reaches if_valid=1 one further cycle later (one bubble).
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous), independent of CLK; first fetch from RESET_PC on first rising edge after Reset returns high.
- Stall held for N cycles: if_instr/if_pc4/if_valid/PC constant for N cycles; instruction input ignored.
- Halt detection while stalled: not evaluated until the stall releases.

## Configuration
- FETCH_HALT_EN: defined -> HALT state and halt detection as above. Undefined -> HALT_OPCODE treated as an ordinary instruction, state machine fixed in RUN, halted tied to 0.

## Test plan
- Reset low then high, ROM returns 32'h2001_0005 at 0 -> after first edge PC=4, if_instr=32'h2001_0005, if_pc4=4, if_valid=1.
- pc_src=1, branch_imm=16'hFFFE at PC=8 -> next PC = 12 - 8 = 4; if_valid=0 for that edge.
- pc_src=2, jump_index=26'h000_0010 at PC=32'h1000_0000 -> PC=32'h1000_0040; pc_src=3, jr_target=32'h0000_0023 -> PC=32'h0000_0020.
- stall=1 for 3 cycles at PC=16 -> PC=16, IF/ID unchanged; stall=1 with pc_src=2 same cycle -> jump taken, IF/ID cleared.
- FETCH_HALT_EN defined, instruction 32'hFC00_0000 at PC=20 -> if_valid=1 once with that instruction, PC stays 20, halted=1, if_valid=0 afterward; then pc_src=3, jr_target=0 -> PC=0, halted=0.
- Reset driven low asynchronously mid-cycle while running -> PC=RESET_PC, if_valid=0, halted=0 before next CLK edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, next-PC select, IF/ID register and halt FSM.
// Optional macro FETCH_HALT_EN enables halt detection and the HALT state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic [31:0] instruction,
  output logic [31:0] PC,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        halted
);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc4_q;
  logic        if_valid_q;
  logic [31:0] pc4;
  logic [31:0] target_d;
  logic        redirect;
  logic        is_halt;
  logic        unused_jr_low;

  assign pc4      = pc_q + 32'd4;
  assign redirect = (pc_src != 2'd0);
  assign is_halt  = HALT_EN && (instruction[31:26] == HALT_OPCODE);
  assign unused_jr_low = ^jr_target[1:0];

  always_comb begin
    target_d = pc4;
    case (pc_src)
      2'd1:    target_d = pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
      2'd2:    target_d = {pc4[31:28], jump_index, 2'b00};
      2'd3:    target_d = {jr_target[31:2], 2'b00};
      default: target_d = pc4;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      if_instr_q <= 32'd0;
      if_pc4_q   <= 32'd0;
      if_valid_q <= 1'b0;
    end else if (redirect) begin
      // Redirect squashes both the fetch slot and IF/ID, even under stall.
      state_q    <= S_RUN;
      pc_q       <= target_d;
      if_instr_q <= 32'd0;
      if_valid_q <= 1'b0;
    end else if (!stall) begin
      if (state_q == S_RUN) begin
        if_instr_q <= instruction;
        if_pc4_q   <= pc4;
        if_valid_q <= 1'b1;
        if (is_halt) begin
          state_q <= S_HALT;
        end else begin
          pc_q <= pc4;
        end
      end else begin
        if_instr_q <= 32'd0;
        if_valid_q <= 1'b0;
      end
    end
  end

  assign PC       = pc_q;
  assign if_instr = if_instr_q;
  assign if_pc4   = if_pc4_q;
  assign if_valid = if_valid_q;
  assign halted   = HALT_EN && (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a behavioural fetch model.
module tb_fetch_unit;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset;
  logic        stall;
  logic [1:0]  pc_src;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        halted;

  logic [31:0] rom [64];

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt;
  int          vectors = 0;
  int          errors  = 0;

  fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .stall(stall), .pc_src(pc_src),
    .branch_imm(branch_imm), .jump_index(jump_index), .jr_target(jr_target),
    .instruction(instruction), .PC(PC), .if_instr(if_instr), .if_pc4(if_pc4),
    .if_valid(if_valid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  always_comb instruction = rom[PC[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PC"}, PC, m_pc);
    chk({tag, ".if_instr"}, if_instr, m_instr);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, m_valid});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halt});
    if (m_valid) chk({tag, ".if_pc4"}, if_pc4, m_pc4);
    $display("%s: PC=%h if_instr=%h if_pc4=%h if_valid=%0d halted=%0d",
             tag, PC, if_instr, if_pc4, if_valid, halted);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] seq, tgt, ins;
    int          off;
    seq = m_pc + 32'd4;
    if (pc_src != 2'd0) begin
      off = int'($signed(branch_imm));
      case (pc_src)
        2'd1:    tgt = seq + 32'(off * 4);
        2'd2:    tgt = (seq & 32'hF000_0000) | (32'(jump_index) * 32'd4);
        default: tgt = jr_target & ~32'h3;
      endcase
      m_pc = tgt; m_valid = 1'b0; m_instr = 32'd0; m_halt = 1'b0;
    end else if (!stall) begin
      if (!m_halt) begin
        ins = rom[m_pc[7:2]];
        m_instr = ins; m_pc4 = seq; m_valid = 1'b1;
        if (HALT_EN && ins[31:26] == 6'h3F) m_halt = 1'b1;
        else m_pc = seq;
      end else begin
        m_valid = 1'b0; m_instr = 32'd0;
      end
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic s, input logic [1:0] src, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] jr);
    stall = s; pc_src = src; branch_imm = imm; jump_index = idx; jr_target = jr;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom[i] = $urandom;
      if (rom[i][31:26] == 6'h3F) rom[i][26] = 1'b0;
    end
    rom[0]  = 32'h2001_0005;
    rom[5]  = 32'hFC00_0000;
    rom[37] = 32'hFC00_1234;
    rom[50] = 32'hFFFF_FFFF;

    set_in(1'b0, 2'd0, 16'd0, 26'd0, 32'd0);
    Reset = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    Reset = 1'b1;

    tick("first_fetch");
    set_in(1'b0, 2'd0, 16'd0, 26'd0, 32'd0);    tick("seq_to_8");
    set_in(1'b0, 2'd1, 16'hFFFE, 26'd0, 32'd0); tick("branch_back");
    set_in(1'b0, 2'd3, 16'd0, 26'd0, 32'h1000_0000); tick("jr_hi");
    set_in(1'b0, 2'd2, 16'd0, 26'h10, 32'd0);   tick("jump");
    set_in(1'b0, 2'd3, 16'd0, 26'd0, 32'h23);   tick("jr_align");
    set_in(1'b0, 2'd3, 16'd0, 26'd0, 32'd16);   tick("jr_16");
    set_in(1'b0, 2'd0, 16'd0, 26'd0, 32'd0);    tick("fill_ifid");
    set_in(1'b1, 2'd0, 16'd0, 26'd0, 32'd0);
    tick("stall1"); tick("stall2"); tick("stall3");
    set_in(1'b1, 2'd2, 16'd0, 26'd5, 32'd0);    tick("stall_jump");
    set_in(1'b0, 2'd0, 16'd0, 26'd0, 32'd0);    tick("halt_fetch");
    tick("halt_hold");
    tick("halt_hold2");
    set_in(1'b0, 2'd3, 16'd0, 26'd0, 32'd0);    tick("halt_exit");
    set_in(1'b0, 2'd3, 16'd0, 26'd0, 32'hFFFF_FFFC); tick("jr_top");
    set_in(1'b0, 2'd0, 16'd0, 26'd0, 32'd0);    tick("wrap");

    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      set_in($urandom_range(0, 4) == 0,
             (r < 7) ? 2'd0 : 2'(r - 6),
             16'($urandom), 26'($urandom), $urandom);
      tick("rand");
    end

    set_in(1'b0, 2'd0, 16'd0, 26'd0, 32'd0);
    tick("pre_async");
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    Reset = 1'b1;
    tick("post_reset_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
